av2_itx_stream: RTL
===================

AV2_ITX_STREAM -- requirements
Module: av2_itx_stream

Interface
REQ-001 SHALL have parameter COEFF_W, default 16, coefficient width (signed).
REQ-002 SHALL have parameter PIX_W, default 16, output pixel width (signed).
REQ-003 SHALL have parameter MAX_LOG2, default 5, maximum transform side log2 (2..MAX_LOG2 legal, i.e. 4..32).
REQ-004 SHALL have ports:
  clk  in  1  sole clock, all logic on rising edge;
  rst  in  1  synchronous, active-high reset;
  start  in  1  single-cycle block request;
  tx_log2_w  in  3  block width log2;
  tx_log2_h  in  3  block height log2;
  tx_mode  in  2  0 raster, 1 transposed, 2 horizontal flip, 3 vertical flip;
  shift  in  3  rounding right-shift amount 0..7;
  coeff_valid  in  1  coefficient stream valid;
  coeff_ready  out  1  coefficient stream ready;
  coeff_data  in  COEFF_W  coefficient, raster order;
  pix_valid  out  1  pixel stream valid;
  pix_ready  in  1  pixel stream ready;
  pix_data  out  PIX_W  pixel value;
  busy  out  1  block in progress;
  done  out  1  one-cycle pulse after last pixel accepted;
  err  out  1  one-cycle pulse on rejected start.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, DRAIN, FIN.
REQ-006 In IDLE, start with legal sizes (2<=log2<=MAX_LOG2 each) SHALL latch tx_log2_w, tx_log2_h, tx_mode, shift, go to LOAD next cycle.
REQ-007 In IDLE, start with illegal size SHALL pulse err next cycle and remain in IDLE.
REQ-008 start outside IDLE SHALL be ignored; latched config SHALL not change until IDLE.
REQ-009 coeff_ready SHALL be 1 exactly in LOAD; each coeff_valid&&coeff_ready SHALL write buffer index k = r*W + c, k from 0.
REQ-010 On handshake of coefficient N-1 (N = W*H) the FSM SHALL go to DRAIN next cycle; coeff_ready SHALL be 0 that next cycle.
REQ-011 DRAIN SHALL emit N pixels in output order j: mode 0 (r,c) raster; mode 1 column-major (c outer, r inner); mode 2 row r, column W-1-c; mode 3 row H-1-r, column c.
REQ-012 Pixel value SHALL be sat_PIX_W((x + R) >>> shift), R = 0 when shift=0 else 1<<(shift-1), sum computed at COEFF_W+1 bits, saturating to [-2^(PIX_W-1), 2^(PIX_W-1)-1].
REQ-013 Buffer read SHALL be synchronous one-cycle; first pix_valid SHALL assert 2 cycles after last coefficient handshake.
REQ-014 While pix_valid && !pix_ready, pix_valid and pix_data SHALL hold stable; no pixel SHALL be dropped or duplicated.
REQ-015 With pix_ready held 1, throughput SHALL be one pixel per cycle, no bubbles within a block.
REQ-016 On handshake of pixel N-1 the FSM SHALL go to FIN; done SHALL pulse in FIN for one cycle; next state IDLE.
REQ-017 busy SHALL be 1 in LOAD, DRAIN, FIN; 0 in IDLE.
REQ-018 pix_valid SHALL never assert outside DRAIN; coeff_valid outside LOAD SHALL be ignored.

Reset
REQ-019 rst SHALL force IDLE; coeff_ready, pix_valid, busy, done, err = 0; pix_data = 0; counters = 0.
REQ-020 rst asserted mid-LOAD or mid-DRAIN SHALL abort the block; outputs SHALL take reset values the cycle after rst is sampled; buffer contents need not be cleared.

Structure
REQ-021 Package av2_itx_pkg SHALL hold the state enum, tx_mode enum, MIN_LOG2=2 constant.
REQ-022 Buffer SHALL be sub-module av2_itx_coeff_ram: simple dual-port, 2^(2*MAX_LOG2) x COEFF_W, one write port, one synchronous read port.
REQ-023 Address generation, rounding/saturation and FSM SHALL reside in av2_itx_stream.

Verification
REQ-024 4x4, mode 0, shift 0, coeffs 0..15 -> pixels 0..15 in order; done pulses one cycle after 16th pixel handshake.
REQ-025 4x4, mode 1, coeffs 0..15 -> 0,4,8,12,1,5,9,13,...,15; mode 2 -> first row 3,2,1,0; mode 3 -> first row 12,13,14,15.
REQ-026 shift 1, coeffs -3, 3, 5 -> -1, 2, 3; PIX_W=8, shift 0, coeff 300 -> 127, coeff -300 -> -128.
REQ-027 8x4 raster, pix_ready low 3 cycles at pixel 5 -> pix_data stable at 5 for 4 cycles, all 32 pixels unique and in order.
REQ-028 start with tx_log2_w=6 (MAX_LOG2=5) -> err pulse 1 cycle, busy stays 0; start during DRAIN -> ignored, block completes unchanged.
REQ-029 rst asserted at pixel 7 of 16x16 -> pix_valid=0, busy=0 next cycle; following 4x4 block completes correctly.

Source files
------------

// File: rtl/av2_itx_pkg.sv
// Shared types and constants for the AV2 inverse-transform output streamer.
// Holds the controller state enum, the output-ordering mode enum, the minimum
// legal block side (log2), and a helper that tests whether a log2 side is legal.
package av2_itx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } itx_state_e;

    typedef enum logic [1:0] {
        MODE_RASTER    = 2'd0,
        MODE_TRANSPOSE = 2'd1,
        MODE_HFLIP     = 2'd2,
        MODE_VFLIP     = 2'd3
    } itx_mode_e;

    localparam int MIN_LOG2 = 2;

    // A side is legal when MIN_LOG2 <= log2 <= max_log2.
    function automatic logic size_legal(input logic [2:0] log2_side, input int max_log2);
        return (int'(log2_side) >= MIN_LOG2) && (int'(log2_side) <= max_log2);
    endfunction

endpackage

// File: rtl/av2_itx_coeff_ram.sv
// Coefficient block buffer: simple dual-port RAM, one write port and one
// synchronous read port with read enable (output holds when rd_en is low).
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr    read request, data appears on rd_data one cycle later
//   rd_data          registered read data
module av2_itx_coeff_ram
    import av2_itx_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/av2_itx_stream.sv
// AV2 inverse-transform output streamer. Accepts a W x H block of signed
// coefficients in raster order, buffers it, then streams it back out in one of
// four orders (raster, transposed, horizontal flip, vertical flip) with a
// rounding right shift and saturation to PIX_W bits.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   start, tx_log2_w, tx_log2_h,
//   tx_mode, shift                    block request and its configuration
//   coeff_valid/coeff_ready/coeff_data  coefficient input stream
//   pix_valid/pix_ready/pix_data        pixel output stream
//   busy, done, err                   status: block active, block finished,
//                                     start rejected for an illegal size
module av2_itx_stream
    import av2_itx_pkg::*;
#(
    parameter int COEFF_W  = 16,
    parameter int PIX_W    = 16,
    parameter int MAX_LOG2 = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         tx_log2_w,
    input  logic [2:0]         tx_log2_h,
    input  logic [1:0]         tx_mode,
    input  logic [2:0]         shift,
    input  logic               coeff_valid,
    output logic               coeff_ready,
    input  logic [COEFF_W-1:0] coeff_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIX_W-1:0]   pix_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int AW = 2 * MAX_LOG2;
    localparam int CW = AW + 1;
    localparam int SW = COEFF_W + 1;
    localparam int WW = (SW > PIX_W) ? SW : PIX_W;
    localparam logic signed [WW-1:0] PIX_MAX = {{(WW-PIX_W+1){1'b0}}, {(PIX_W-1){1'b1}}};
    localparam logic signed [WW-1:0] PIX_MIN = {{(WW-PIX_W+1){1'b1}}, {(PIX_W-1){1'b0}}};

    itx_state_e          state_q, state_d;
    logic [2:0]          log2_w_q, log2_w_d, log2_h_q, log2_h_d, shift_q, shift_d;
    itx_mode_e           mode_q, mode_d;
    logic [CW-1:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, out_cnt_q, out_cnt_d;
    logic [MAX_LOG2-1:0] inner_q, inner_d, outer_q, outer_d;
    logic                pix_valid_q, pix_valid_d, err_q, err_d;

    logic [CW-1:0]       n_total, last_idx;
    logic [MAX_LOG2-1:0] w_mask, h_mask, inner_mask, row, col;
    logic [AW-1:0]       rd_addr;
    logic                advance, issue, wr_en;
    logic [COEFF_W-1:0]  ram_rd_data;

    logic signed [SW-1:0] x_ext, rnd, sum, shifted;
    logic signed [WW-1:0] wide;
    logic [PIX_W-1:0]     sat_val;

    av2_itx_coeff_ram #(
        .DATA_W (COEFF_W),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt_q[AW-1:0]),
        .wr_data (coeff_data),
        .rd_en   (issue),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // Output-order address: walk an inner/outer counter pair, map it onto
    // (row, col), apply the flip, then form r*W + c with a shift.
    always_comb begin
        n_total    = CW'(1) << ({1'b0, log2_w_q} + {1'b0, log2_h_q});
        last_idx   = n_total - CW'(1);
        w_mask     = ~({MAX_LOG2{1'b1}} << log2_w_q);
        h_mask     = ~({MAX_LOG2{1'b1}} << log2_h_q);
        inner_mask = (mode_q == MODE_TRANSPOSE) ? h_mask : w_mask;
        if (mode_q == MODE_TRANSPOSE) begin
            row = inner_q;
            col = outer_q;
        end else begin
            row = outer_q;
            col = inner_q;
        end
        // For c < W, W-1-c equals c XOR (W-1).
        if (mode_q == MODE_HFLIP) begin
            col = col ^ w_mask;
        end
        if (mode_q == MODE_VFLIP) begin
            row = row ^ h_mask;
        end
        rd_addr = (AW'(row) << log2_w_q) | AW'(col);
    end

    // Rounding shift at COEFF_W+1 bits, then clamp to the PIX_W range.
    always_comb begin
        x_ext = {ram_rd_data[COEFF_W-1], ram_rd_data};
        rnd   = '0;
        if (shift_q != 3'd0) begin
            rnd = SW'(1) << (shift_q - 3'd1);
        end
        sum     = x_ext + rnd;
        shifted = sum >>> shift_q;
        wide    = WW'(shifted);
        if (wide > PIX_MAX) begin
            sat_val = PIX_MAX[PIX_W-1:0];
        end else if (wide < PIX_MIN) begin
            sat_val = PIX_MIN[PIX_W-1:0];
        end else begin
            sat_val = wide[PIX_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        log2_w_d    = log2_w_q;
        log2_h_d    = log2_h_q;
        mode_d      = mode_q;
        shift_d     = shift_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_cnt_d   = out_cnt_q;
        inner_d     = inner_q;
        outer_d     = outer_q;
        pix_valid_d = pix_valid_q;
        err_d       = 1'b0;
        wr_en       = 1'b0;
        issue       = 1'b0;
        // The read register doubles as the output stage, so it may only be
        // refilled when it is empty or its pixel is being taken.
        advance     = !pix_valid_q || pix_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_legal(tx_log2_w, MAX_LOG2) && size_legal(tx_log2_h, MAX_LOG2)) begin
                        log2_w_d  = tx_log2_w;
                        log2_h_d  = tx_log2_h;
                        mode_d    = itx_mode_e'(tx_mode);
                        shift_d   = shift;
                        wr_cnt_d  = '0;
                        rd_cnt_d  = '0;
                        out_cnt_d = '0;
                        inner_d   = '0;
                        outer_d   = '0;
                        state_d   = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                wr_en = coeff_valid;
                if (coeff_valid) begin
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    if (wr_cnt_q == last_idx) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                issue = advance && (rd_cnt_q != n_total);
                if (issue) begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                    if (inner_q == inner_mask) begin
                        inner_d = '0;
                        outer_d = outer_q + 1'b1;
                    end else begin
                        inner_d = inner_q + 1'b1;
                    end
                end
                if (advance) begin
                    pix_valid_d = issue;
                end
                if (pix_valid_q && pix_ready) begin
                    out_cnt_d = out_cnt_q + CW'(1);
                    if (out_cnt_q == last_idx) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            log2_w_q    <= '0;
            log2_h_q    <= '0;
            mode_q      <= MODE_RASTER;
            shift_q     <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_cnt_q   <= '0;
            inner_q     <= '0;
            outer_q     <= '0;
            pix_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            log2_w_q    <= log2_w_d;
            log2_h_q    <= log2_h_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inner_q     <= inner_d;
            outer_q     <= outer_d;
            pix_valid_q <= pix_valid_d;
            err_q       <= err_d;
        end
    end

    assign coeff_ready = (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign err         = err_q;
    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_valid_q ? sat_val : '0;

endmodule
